spi_ctrl_master: RTL and testbench
==================================

Name: spi_ctrl_master

Overview:
- SPI mode-0 controller. Drives one 16-bit frame per request: R/W bit, 7-bit address, 8-bit data, MSB first.
- It is the controller end of the register-access link used by the onboarding SPI peripheral (enable/PWM registers).
- Used on-chip as a self-test / loopback driver, and reusable as a bench-side transactor.
- Generates SCLK, nCS and COPI from the system clock. Samples CIPO during the data byte.

Parameters:
CLK_DIV, 4, system clocks per SCLK half-period; legal range 1..255
GAP_CYC, 4, minimum system clocks nCS stays high between frames; legal range 1..255

Ports:
clk     in   1  system clock, all logic on rising edge
rst_n   in   1  asynchronous active-low reset
start   in   1  request pulse; sampled only when busy=0
rw      in   1  1=write, 0=read; sent as frame bit 15
addr    in   7  register address; frame bits 14:8
wdata   in   8  write data; frame bits 7:0 (sent as-is on reads)
busy    out  1  high from accepted start through end of GAP
done    out  1  one-cycle pulse at frame end
rdata   out  8  CIPO bits captured during the data byte; valid when done=1, held until next done
sclk    out  1  SPI clock, idles low
ncs     out  1  chip select, active low, idles high
copi    out  1  controller-out data
cipo    in   1  controller-in data

Behaviour:
- Reset (asynchronous, rst_n=0) and its values:
  - state=IDLE; sclk=0, ncs=1, copi=0, busy=0, done=0, rdata=0x00; all counters 0.
  - Reset mid-frame aborts the frame. Outputs return to reset values immediately; no done is produced.
- State machine:
  - IDLE -> SHIFT -> HOLD -> GAP -> IDLE.
  - All outputs are registered.
  - A half-period counter (0..CLK_DIV-1) and a bit counter (15..0) sequence the frame.
- IDLE:
  - start=1 at edge N latches the shift register = {rw, addr, wdata}.
  - On edge N: ncs<=0, busy<=1, copi<=bit15, sclk stays 0. Enter SHIFT.
  - Inputs are ignored after the latch.
- SHIFT, per bit (16 bits, bit15 first):
  - Low phase: sclk=0 for CLK_DIV cycles. The first bit's low phase is the nCS-to-SCLK setup time.
  - High phase: sclk=1 for CLK_DIV cycles.
  - At the 0->1 SCLK transition the sampled cipo is shifted into rdata_shift. Only bits 7:0 are retained.
  - At the 1->0 transition copi updates to the next bit. After bit 0, copi holds bit 0.
  - Exit SHIFT on the falling edge that ends bit 0's high phase.
- HOLD:
  - sclk=0, ncs=0 for CLK_DIV cycles.
  - Then: ncs<=1, done<=1 for exactly one cycle, rdata<=rdata_shift, copi<=0. Enter GAP.
- GAP:
  - ncs=1 for GAP_CYC cycles, counted from the cycle ncs rises.
  - Then busy<=0 and enter IDLE. The next start is accepted on the first cycle with busy=0.
- Timing totals:
  - ncs low for exactly 33*CLK_DIV cycles.
  - Exactly 16 sclk rising edges per frame.
  - Start-to-done latency = 33*CLK_DIV cycles.
  - Minimum start-to-start spacing = 33*CLK_DIV + GAP_CYC cycles.
- start while busy=1 (including on the done cycle) is ignored and not queued.
- Writes (rw=1) capture CIPO identically to reads; the captured rdata is don't-care to the user.
- CLK_DIV=1:
  - sclk toggles every cycle (SCLK = clk/2).
  - Sequencing must still produce 16 rising edges and all phase lengths above.
- Must never glitch:
  - no sclk edge while ncs=1;
  - copi never changes while sclk=1.

Test Plan:
1. CLK_DIV=4, write rw=1 addr=0x00 wdata=0xF0.
   -> bits sampled on 16 sclk rises = 0x80F0; ncs low 132 cycles; done 1 cycle at start+132; busy low at start+136.
2. Read rw=0 addr=0x05, bench peripheral drives cipo with 0xA5 MSB-first on falling edges during bits 7..0.
   -> COPI stream 0x05xx; rdata=0xA5 when done=1; rdata holds 0xA5 afterwards.
3. start pulsed again 10 cycles into a frame with different addr/wdata.
   -> frame content unchanged (0x80F0); exactly one done; no second frame.
4. start held high continuously across two frames.
   -> second frame begins exactly GAP_CYC cycles after ncs rises; ncs high gap=4 cycles; both frames bit-exact.
5. rst_n asserted during bit 9 of a frame.
   -> same cycle: ncs=1, sclk=0, busy=0, no done. After release, a new write 0x81/0x3C completes correctly (stream 0x813C).
6. CLK_DIV=1 build, write addr=0x02 wdata=0xFF into the onboarding peripheral.
   -> peripheral register 0x02 reads back 0xFF; ncs low 33 cycles; 16 sclk rises.

Source files
------------

// File: rtl/spi_ctrl_master.sv
// SPI mode-0 controller: one 16-bit {rw, addr[6:0], data[7:0]} frame per accepted start, MSB first.
// CIPO is sampled on every SCLK rise; the last eight samples (the data byte) become rdata.
module spi_ctrl_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       ncs,
  output logic       copi,
  input  logic       cipo
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYC - 2);

  state_t      state, state_d;
  logic [7:0]  half_cnt, half_d;
  logic [3:0]  bit_cnt, bit_d;
  logic [7:0]  gap_cnt, gap_d;
  logic [14:0] tx_sr, tx_d;
  logic [7:0]  rdata_shift, rx_d;
  logic        sclk_d, ncs_d, copi_d, busy_d, done_d;
  logic [7:0]  rdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      half_cnt    <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      tx_sr       <= '0;
      rdata_shift <= '0;
      sclk        <= 1'b0;
      ncs         <= 1'b1;
      copi        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rdata       <= '0;
    end else begin
      state       <= state_d;
      half_cnt    <= half_d;
      bit_cnt     <= bit_d;
      gap_cnt     <= gap_d;
      tx_sr       <= tx_d;
      rdata_shift <= rx_d;
      sclk        <= sclk_d;
      ncs         <= ncs_d;
      copi        <= copi_d;
      busy        <= busy_d;
      done        <= done_d;
      rdata       <= rdata_d;
    end
  end

  always_comb begin
    state_d = state;
    half_d  = half_cnt;
    bit_d   = bit_cnt;
    gap_d   = gap_cnt;
    tx_d    = tx_sr;
    rx_d    = rdata_shift;
    sclk_d  = sclk;
    ncs_d   = ncs;
    copi_d  = copi;
    busy_d  = busy;
    done_d  = 1'b0;
    rdata_d = rdata;
    unique case (state)
      IDLE: begin
        if (start) begin
          // Frame bit 15 goes straight to COPI; tx_sr holds the remaining 15 bits.
          tx_d    = {addr, wdata};
          copi_d  = rw;
          ncs_d   = 1'b0;
          busy_d  = 1'b1;
          sclk_d  = 1'b0;
          half_d  = '0;
          bit_d   = 4'd15;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (half_cnt == HALF_LAST) begin
          half_d = '0;
          if (!sclk) begin
            sclk_d = 1'b1;
            rx_d   = {rdata_shift[6:0], cipo};
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt == 4'd0) begin
              state_d = HOLD;
            end else begin
              bit_d  = bit_cnt - 4'd1;
              copi_d = tx_sr[14];
              tx_d   = {tx_sr[13:0], 1'b0};
            end
          end
        end else begin
          half_d = half_cnt + 8'd1;
        end
      end
      HOLD: begin
        if (half_cnt == HALF_LAST) begin
          half_d  = '0;
          ncs_d   = 1'b1;
          done_d  = 1'b1;
          rdata_d = rdata_shift;
          copi_d  = 1'b0;
          gap_d   = '0;
          // IDLE itself is the last nCS-high cycle, so GAP holds for GAP_CYC-1 cycles.
          if (GAP_CYC == 1) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = GAP;
          end
        end else begin
          half_d = half_cnt + 8'd1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_d = gap_cnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_ctrl_master.sv
// Scoreboard bench for spi_ctrl_master: CLK_DIV=4 and CLK_DIV=1 instances, each wired to a
// small register-file peripheral model that records the COPI stream and answers reads on CIPO.
`timescale 1ns/1ps
module tb_spi_ctrl_master;

  localparam int unsigned GAP = 4;

  typedef struct {
    int          inst;
    logic [15:0] frame;
    logic [7:0]  rd;
    int          t0;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      start, rw, busy, done, sclk, ncs, copi;
  logic [1:0]      cipo;
  logic [1:0][6:0] addr;
  logic [1:0][7:0] wdata, rdata;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   dones [2] = '{0, 0};
  exp_t exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  spi_ctrl_master #(.CLK_DIV(4), .GAP_CYC(GAP)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .rw(rw[0]), .addr(addr[0]), .wdata(wdata[0]),
    .busy(busy[0]), .done(done[0]), .rdata(rdata[0]), .sclk(sclk[0]), .ncs(ncs[0]),
    .copi(copi[0]), .cipo(cipo[0])
  );

  spi_ctrl_master #(.CLK_DIV(1), .GAP_CYC(GAP)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .rw(rw[1]), .addr(addr[1]), .wdata(wdata[1]),
    .busy(busy[1]), .done(done[1]), .rdata(rdata[1]), .sclk(sclk[1]), .ncs(ncs[1]),
    .copi(copi[1]), .cipo(cipo[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_per
    logic [15:0] sr = '0;
    logic [15:0] last_frame = '0;
    logic [7:0]  rd_byte = '0;
    logic [7:0]  regs [128] = '{5: 8'hA5, default: 8'h00};
    logic        p_ncs = 1'b1, p_sk = 1'b0, cipo_b = 1'b0, h_sk = 1'b0, h_copi = 1'b0;
    int          rises = 0, falls = 0, t_fall = 0, ncs_len = 0, last_rises = 0;
    int          sclk_glitch = 0, copi_glitch = 0;

    assign cipo[g] = cipo_b;

    always @(ncs[g] or sclk[g]) begin
      if (ncs[g] == 1'b0 && p_ncs == 1'b1) begin
        sr = '0; rises = 0; falls = 0; t_fall = cyc; cipo_b = 1'b0;
      end
      if (ncs[g] == 1'b1 && p_ncs == 1'b0) begin
        ncs_len = cyc - t_fall;
        last_frame = sr;
        last_rises = rises;
        if (rises == 16 && sr[15]) regs[sr[14:8]] = sr[7:0];
        cipo_b = 1'b0;
      end
      if (sclk[g] == 1'b1 && p_sk == 1'b0) begin
        if (ncs[g] != 1'b0) sclk_glitch++;
        sr = {sr[14:0], copi[g]};
        rises++;
      end
      if (sclk[g] == 1'b0 && p_sk == 1'b1 && ncs[g] == 1'b0) begin
        falls++;
        // After eight rises sr holds {rw, addr}; reads return the addressed register.
        if (falls == 8) rd_byte = sr[7] ? 8'h00 : regs[sr[6:0]];
        if (falls >= 8 && falls < 16) begin
          cipo_b = rd_byte[7];
          rd_byte = {rd_byte[6:0], 1'b0};
        end
      end
      p_ncs = ncs[g];
      p_sk = sclk[g];
    end

    always @(negedge clk) begin
      if (h_sk == 1'b1 && sclk[g] == 1'b1 && copi[g] != h_copi) copi_glitch++;
      h_sk = sclk[g];
      h_copi = copi[g];
    end
  end

  task automatic chk(input string name, input int g, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s inst=%0d got=0x%0h want=0x%0h", name, g, got, want);
    end
  endtask

  task automatic on_done(input int g, input logic [15:0] fr, input int nrise, input int nlen);
    exp_t e;
    int   div;
    div = (g == 0) ? 4 : 1;
    dones[g]++;
    if (exp_q.size() == 0 || exp_q[0].inst != g) begin
      errors++;
      $display("FAIL unexpected_done inst=%0d got done=1 frame=0x%0h want no frame pending", g, fr);
    end else begin
      e = exp_q.pop_front();
      chk("frame", g, 32'(fr), 32'(e.frame));
      chk("sclk_rises", g, nrise, 16);
      chk("ncs_low_cycles", g, nlen, 33 * div);
      chk("start_to_done", g, cyc - e.t0, 33 * div);
      chk("rdata", g, 32'(rdata[g]), 32'(e.rd));
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (done[0] === 1'b1) on_done(0, g_per[0].last_frame, g_per[0].last_rises, g_per[0].ncs_len);
    if (done[1] === 1'b1) on_done(1, g_per[1].last_frame, g_per[1].last_rises, g_per[1].ncs_len);
  end

  task automatic at_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    while ((busy[g] !== 1'b0 || exp_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) begin
      errors++;
      $display("FAIL timeout_idle inst=%0d got busy=%0b pending=%0d want 0", g, busy[g], exp_q.size());
    end
  endtask

  task automatic issue(input int g, input logic r, input logic [6:0] a, input logic [7:0] d,
                       input logic [15:0] ef, input logic [7:0] er, input bit push, output int t0);
    int n;
    n = 0;
    while (busy[g] !== 1'b0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) begin
      errors++;
      $display("FAIL timeout_busy inst=%0d got busy=1 want 0", g);
    end
    @(negedge clk);
    start[g] = 1'b1; rw[g] = r; addr[g] = a; wdata[g] = d;
    @(posedge clk);
    #1;
    start[g] = 1'b0;
    t0 = cyc;
    if (push) exp_q.push_back('{g, ef, er, t0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200us");
    $fatal(1);
  end

  initial begin
    int t, t2, td, n, d0;
    start = '0; rw = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_ncs", g, 32'(ncs[g]), 1);
      chk("rst_sclk", g, 32'(sclk[g]), 0);
      chk("rst_copi", g, 32'(copi[g]), 0);
      chk("rst_busy", g, 32'(busy[g]), 0);
      chk("rst_done", g, 32'(done[g]), 0);
      chk("rst_rdata", g, 32'(rdata[g]), 0);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Write 0x00 <- 0xF0 with boundary timing of done and busy.
    issue(0, 1'b1, 7'h00, 8'hF0, 16'h80F0, 8'h00, 1'b1, t);
    at_cyc(t + 131); chk("done_early", 0, 32'(done[0]), 0);
    at_cyc(t + 132); chk("done_at_132", 0, 32'(done[0]), 1);
                     chk("ncs_at_done", 0, 32'(ncs[0]), 1);
    at_cyc(t + 133); chk("done_one_cycle", 0, 32'(done[0]), 0);
    at_cyc(t + 134); chk("busy_in_gap", 0, 32'(busy[0]), 1);
    at_cyc(t + 136); chk("busy_low_136", 0, 32'(busy[0]), 0);

    // Read 0x05; peripheral answers 0xA5.
    issue(0, 1'b0, 7'h05, 8'h00, 16'h0500, 8'hA5, 1'b1, t);
    at_cyc(t + 200); chk("rdata_held", 0, 32'(rdata[0]), 32'h0000_00A5);

    // Second start 10 cycles into a frame is dropped.
    issue(0, 1'b1, 7'h00, 8'hF0, 16'h80F0, 8'h00, 1'b1, t);
    d0 = dones[0];
    at_cyc(t + 9);
    @(negedge clk);
    start[0] = 1'b1; rw[0] = 1'b0; addr[0] = 7'h55; wdata[0] = 8'h12;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    at_cyc(t + 400);
    chk("single_done", 0, dones[0] - d0, 1);
    chk("ncs_idle_after", 0, 32'(ncs[0]), 1);

    // start held high across two frames.
    wait_idle(0);
    @(negedge clk);
    start[0] = 1'b1; rw[0] = 1'b1; addr[0] = 7'h2A; wdata[0] = 8'h5A;
    @(posedge clk);
    #1;
    t = cyc;
    exp_q.push_back('{0, 16'hAA5A, 8'h00, t});
    n = 0;
    while (done[0] !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
    td = cyc;
    chk("held_first_done", 0, 32'(done[0]), 1);
    n = 0;
    while (ncs[0] !== 1'b0 && n < 50) begin @(posedge clk); #1; n++; end
    t2 = cyc;
    chk("held_gap_cycles", 0, t2 - td, GAP);
    exp_q.push_back('{0, 16'hAA5A, 8'h00, t2});
    @(negedge clk);
    start[0] = 1'b0;
    wait_idle(0);

    // Reset during bit 9 aborts the frame.
    issue(0, 1'b1, 7'h7F, 8'hAA, 16'hFFAA, 8'h00, 1'b0, t);
    at_cyc(t + 53);
    chk("mid_frame_sclk", 0, 32'(sclk[0]), 1);
    d0 = dones[0];
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ncs", 0, 32'(ncs[0]), 1);
    chk("abort_sclk", 0, 32'(sclk[0]), 0);
    chk("abort_busy", 0, 32'(busy[0]), 0);
    chk("abort_done", 0, 32'(done[0]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", 0, dones[0] - d0, 0);
    issue(0, 1'b1, 7'h01, 8'h3C, 16'h813C, 8'h00, 1'b1, t);
    wait_idle(0);

    // CLK_DIV=1: write then read back register 0x02.
    issue(1, 1'b1, 7'h02, 8'hFF, 16'h82FF, 8'h00, 1'b1, t);
    wait_idle(1);
    issue(1, 1'b0, 7'h02, 8'h00, 16'h0200, 8'hFF, 1'b1, t);
    wait_idle(1);
    chk("periph_reg2", 1, 32'(g_per[1].regs[2]), 32'h0000_00FF);

    repeat (10) @(posedge clk);
    #1;
    chk("sclk_edge_ncs_high", 0, g_per[0].sclk_glitch, 0);
    chk("sclk_edge_ncs_high", 1, g_per[1].sclk_glitch, 0);
    chk("copi_change_sclk_high", 0, g_per[0].copi_glitch, 0);
    chk("copi_change_sclk_high", 1, g_per[1].copi_glitch, 0);
    chk("scoreboard_empty", 0, exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
